// File: rtl/sram_arb_pkg.sv
// Shared widths and types for the SRAM controller request-port arbiter.
package sram_arb_pkg;

  localparam int unsigned SRAM_ADDR_W = 20;
  localparam int unsigned SRAM_DATA_W = 16;

  typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;
  typedef logic [SRAM_DATA_W-1:0] sram_data_t;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10
  } sram_op_e;

endpackage

// File: rtl/sram_tag_fifo.sv
// In-order FIFO of requester IDs for outstanding reads.
// The caller never pushes when full nor pops when empty.
module sram_tag_fifo #(
  parameter int unsigned ID_W  = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [ID_W-1:0]        push_id_i,
  input  logic                   pop_i,
  output logic [ID_W-1:0]        head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_id_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM controller request port; read returns are
// steered back by an in-order tag FIFO. Define SRAM_ARB_PRIORITY_EN for requester-0 priority.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic                     BOARD_CLK,
  input  logic                     RESET,
  input  logic       [NUM_REQ-1:0] req_valid,
  input  logic       [NUM_REQ-1:0] req_write,
  input  sram_addr_t [NUM_REQ-1:0] req_addr,
  input  sram_data_t [NUM_REQ-1:0] req_wdata,
  output logic       [NUM_REQ-1:0] req_ready,
  input  logic                     q_full,
  output logic                     q_read_req,
  output logic                     q_write_req,
  output sram_addr_t               q_addr,
  output sram_data_t               q_wdata,
  input  logic                     port_rd_valid,
  input  sram_data_t               port_rd_data,
  output logic       [NUM_REQ-1:0] rd_valid,
  output sram_data_t               rd_data,
  output logic                     err_orphan
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TAG_DEPTH) + 1;

  logic [ID_W-1:0]    last_grant_q;
  sram_op_e           op_q;
  sram_addr_t         q_addr_q;
  sram_data_t         q_wdata_q;
  logic [NUM_REQ-1:0] rd_valid_q;
  sram_data_t         rd_data_q;
  logic               err_q;

  logic [NUM_REQ-1:0] eligible;
  logic               grant_vld;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_wr;
  logic               lg_upd;
  int unsigned        scan_idx;
  logic [ID_W-1:0]    scan_id;
  logic               rr_ok;

  logic               tag_push;
  logic               tag_pop;
  logic [ID_W-1:0]    tag_head;
  logic [CNT_W-1:0]   tag_count;
  logic               tag_full;
  logic               tag_empty;

  // Read eligibility uses the registered FIFO state, so a same-cycle pop cannot unblock it.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] & ~q_full & (req_write[i] | ~tag_full);
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    scan_id   = '0;
    rr_ok     = 1'b0;
    req_ready = '0;
`ifdef SRAM_ARB_PRIORITY_EN
    grant_vld = eligible[0];
`endif
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (32'(last_grant_q) + k) % NUM_REQ;
      scan_id  = ID_W'(scan_idx);
`ifdef SRAM_ARB_PRIORITY_EN
      rr_ok = (scan_id != '0);
`else
      rr_ok = 1'b1;
`endif
      if (!grant_vld && rr_ok && eligible[scan_id]) begin
        grant_vld = 1'b1;
        grant_idx = scan_id;
      end
    end
    if (grant_vld) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign grant_wr = req_write[grant_idx];
  assign tag_push = grant_vld & ~grant_wr;
  assign tag_pop  = port_rd_valid & (tag_count != '0);
`ifdef SRAM_ARB_PRIORITY_EN
  assign lg_upd = grant_vld & (grant_idx != '0);
`else
  assign lg_upd = grant_vld;
`endif

  sram_tag_fifo #(
    .ID_W  (ID_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk_i     (BOARD_CLK),
    .rst_i     (RESET),
    .push_i    (tag_push),
    .push_id_i (grant_idx),
    .pop_i     (tag_pop),
    .head_o    (tag_head),
    .count_o   (tag_count),
    .full_o    (tag_full),
    .empty_o   (tag_empty)
  );

  always_ff @(posedge BOARD_CLK) begin
    if (RESET) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      op_q         <= OP_NONE;
      q_addr_q     <= '0;
      q_wdata_q    <= '0;
      rd_valid_q   <= '0;
      rd_data_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      if (lg_upd) begin
        last_grant_q <= grant_idx;
      end
      if (grant_vld) begin
        op_q      <= grant_wr ? OP_WRITE : OP_READ;
        q_addr_q  <= req_addr[grant_idx];
        q_wdata_q <= grant_wr ? req_wdata[grant_idx] : '0;
      end else begin
        op_q <= OP_NONE;
      end
      rd_valid_q <= '0;
      if (tag_pop) begin
        rd_valid_q[tag_head] <= 1'b1;
        rd_data_q            <= port_rd_data;
      end
      if (port_rd_valid && tag_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  assign q_read_req  = (op_q == OP_READ);
  assign q_write_req = (op_q == OP_WRITE);
  assign q_addr      = q_addr_q;
  assign q_wdata     = q_wdata_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign err_orphan  = err_q;

endmodule
